// File: rtl/pdp11_iopage_pkg.sv
// Shared iopage definitions: arbiter state encoding, device vectors, bus-request levels.
// Latency: n/a (constants and a width helper only).
// Backpressure: n/a.
package pdp11_iopage_pkg;

   // Arbiter handshake states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } arb_state_t;

   // Fixed interrupt vectors of the iopage devices
   localparam logic [7:0] VEC_KW11L = 8'o100;
   localparam logic [7:0] VEC_TTI   = 8'o60;
   localparam logic [7:0] VEC_TTO   = 8'o64;
   localparam logic [7:0] VEC_RK    = 8'o220;

   // Bus-request levels
   localparam logic [2:0] BR4 = 3'd4;
   localparam logic [2:0] BR5 = 3'd5;
   localparam logic [2:0] BR6 = 3'd6;
   localparam logic [2:0] BR7 = 3'd7;

   // Width of a device index; a single device still needs one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/int_arb_pick.sv
// Combinational priority pick: highest level among requests above cpu_ipl, lowest index on ties.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to sample the result.
module int_arb_pick
   import pdp11_iopage_pkg::*;
#(
   parameter  int NDEV = 4,
   localparam int IW   = idx_width(NDEV)
) (
   input  logic [NDEV-1:0]   req,
   input  logic [3*NDEV-1:0] lvl,
   input  logic [2:0]        cpu_ipl,
   output logic              any,
   output logic [IW-1:0]     win_idx,
   output logic [2:0]        win_lvl
);

   logic [2:0] lvl_i;

   // Scan upward; only a strictly higher level displaces the current best, so ties keep the lower index
   always_comb begin
      any     = 1'b0;
      win_idx = '0;
      win_lvl = '0;
      lvl_i   = '0;
      for (int i = 0; i < NDEV; i++) begin
         lvl_i = lvl[3*i +: 3];
         if (req[i] && (lvl_i > cpu_ipl) && (!any || (lvl_i > win_lvl))) begin
            any     = 1'b1;
            win_idx = IW'(i);
            win_lvl = lvl_i;
         end
      end
   end

endmodule

// File: rtl/iopage_int_arb.sv
// Interrupt arbiter between iopage devices and the CPU: pick, request/acknowledge handshake, device ack pulse.
// Latency: interrupt rises one cycle after an eligible request; dev_ack pulses on the edge that sees int_ack.
// Backpressure: CPU holds int_ack until interrupt drops; no new request is evaluated until int_ack falls.
module iopage_int_arb
   import pdp11_iopage_pkg::*;
#(
   parameter int NDEV = 4,
   // Device 0 in the LSBs: devices 0,1 at BR4, device 2 at BR5, device 3 at BR6
   parameter logic [3*NDEV-1:0] DEV_IPL = {BR6, BR5, BR4, BR4}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NDEV-1:0]   dev_int,
   input  logic [8*NDEV-1:0] dev_vector,
   input  logic [2:0]        cpu_ipl,
   input  logic              int_ack,
   output logic              interrupt,
   output logic [7:0]        vector,
   output logic [2:0]        int_ipl,
   output logic [NDEV-1:0]   dev_ack
);

   localparam int IW = idx_width(NDEV);

   arb_state_t    state;
   logic [IW-1:0] win_q;
   logic          pick_any;
   logic [IW-1:0] pick_idx;
   logic [2:0]    pick_lvl;
   logic [2:0]    win_lvl_cur;
   logic          win_elig;
   logic          take_pick;

   int_arb_pick #(
      .NDEV    (NDEV)
   ) u_pick (
      .req     (dev_int),
      .lvl     (DEV_IPL),
      .cpu_ipl (cpu_ipl),
      .any     (pick_any),
      .win_idx (pick_idx),
      .win_lvl (pick_lvl)
   );

   // The latched winner stays eligible only while it still requests above the CPU priority
   assign win_lvl_cur = DEV_IPL[3*win_q +: 3];
   assign win_elig    = dev_int[win_q] && (win_lvl_cur > cpu_ipl);

   // Decide whether this edge loads a new winner; int_ack in REQ overrides both withdrawal and preemption
   always_comb begin
      take_pick = 1'b0;
      case (state)
         ST_IDLE: take_pick = pick_any;
         ST_REQ:  take_pick = !int_ack && pick_any && (!win_elig || (pick_lvl > int_ipl));
         default: take_pick = 1'b0;
      endcase
   end

   // Handshake FSM with registered outputs; vector is re-sampled only when the winner changes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         win_q     <= '0;
         interrupt <= 1'b0;
         vector    <= '0;
         int_ipl   <= '0;
         dev_ack   <= '0;
      end else begin
         dev_ack <= '0;
         if (take_pick) begin
            win_q   <= pick_idx;
            vector  <= dev_vector[8*pick_idx +: 8];
            int_ipl <= pick_lvl;
         end
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  interrupt <= 1'b1;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  dev_ack   <= NDEV'(1) << win_q;
                  interrupt <= 1'b0;
                  state     <= ST_ACK;
               end else if (!win_elig && !pick_any) begin
                  interrupt <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_ACK: begin
               if (!int_ack) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               interrupt <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
